// File: rtl/sync_fifo_ptr_ctrl_pkg.sv
// sync_fifo_ptr_ctrl_pkg: shared defaults for the FIFO pointer controller
package sync_fifo_ptr_ctrl_pkg;
    `include "sync_fifo_defines.vh"
    localparam int FIFO_DEPTH_DEFAULT = `FIFO_DEPTH;
endpackage

// File: rtl/sync_fifo_defines.vh
// sync_fifo_defines: shared FIFO build-time defaults
`ifndef SYNC_FIFO_DEFINES_VH
`define SYNC_FIFO_DEFINES_VH
`define FIFO_DEPTH 16
`endif

// File: rtl/sync_fifo_ptr_cnt.sv
// sync_fifo_ptr_cnt: wrapping pointer counter
//   clk, rst : clock, sync active-high reset
//   clr      : synchronous clear
//   inc      : advance by one, wrapping modulo 2^W
//   cnt      : registered count
module sync_fifo_ptr_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (inc)   cnt <= cnt + 1'b1;
endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// sync_fifo_ptr_ctrl: synchronous FIFO read/write pointer controller
//   clk, rst              : clock, sync active-high reset
//   i_valid_s, i_ready_m  : write / read requests
//   i_flush               : synchronous pointer clear
//   i_full, i_empty       : flags from the external comparator
//   o_wr_en, o_rd_en      : memory strobes (combinational)
//   wr_addr, rd_addr      : registered pointers, MSB is the wrap bit
//   o_rd_valid            : read data valid, one cycle after o_rd_en
//   o_overflow/underflow  : sticky blocked-request flags
module sync_fifo_ptr_ctrl
    import sync_fifo_ptr_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid_s,
    input  logic                i_ready_m,
    input  logic                i_flush,
    input  logic                i_full,
    input  logic                i_empty,
    output logic                o_wr_en,
    output logic                o_rd_en,
    output logic [ADDR_WIDTH:0] wr_addr,
    output logic [ADDR_WIDTH:0] rd_addr,
    output logic                o_rd_valid,
    output logic                o_overflow,
    output logic                o_underflow
);
    assign o_wr_en = ~rst & i_valid_s & ~i_full & ~i_flush;
    assign o_rd_en = ~rst & i_ready_m & ~i_empty & ~i_flush;

    sync_fifo_ptr_cnt #(.W(ADDR_WIDTH + 1)) u_wr_cnt (
        .clk(clk), .rst(rst), .clr(i_flush), .inc(o_wr_en), .cnt(wr_addr)
    );

    sync_fifo_ptr_cnt #(.W(ADDR_WIDTH + 1)) u_rd_cnt (
        .clk(clk), .rst(rst), .clr(i_flush), .inc(o_rd_en), .cnt(rd_addr)
    );

    always_ff @(posedge clk)
        if (rst || i_flush) begin
            o_rd_valid  <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_rd_valid <= o_rd_en;
            if (i_valid_s && i_full)  o_overflow  <= 1'b1;
            if (i_ready_m && i_empty) o_underflow <= 1'b1;
        end
endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// tb_sync_fifo_ptr_ctrl: randomized + directed check against an occupancy model
module tb_sync_fifo_ptr_ctrl;
    localparam int DEPTH = 16;
    localparam int PMOD  = 2 * DEPTH;

    logic       clk = 1'b0;
    logic       rst, i_valid_s, i_ready_m, i_flush, i_full, i_empty;
    logic       o_wr_en, o_rd_en, o_rd_valid, o_overflow, o_underflow;
    logic [4:0] wr_addr, rd_addr;

    int checks = 0;
    int errors = 0;

    int  m_wr = 0, m_rd = 0;
    bit  m_rv = 0, m_ovf = 0, m_unf = 0;
    bit  rand_flags = 0;

    always #5 clk = ~clk;

    sync_fifo_ptr_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid_s(i_valid_s), .i_ready_m(i_ready_m),
        .i_flush(i_flush), .i_full(i_full), .i_empty(i_empty),
        .o_wr_en(o_wr_en), .o_rd_en(o_rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .o_rd_valid(o_rd_valid), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int occ();
        return (m_wr - m_rd + PMOD) % PMOD;
    endfunction

    task automatic cycle(input bit v, input bit r, input bit fl, input bit rs);
        bit full, empty, ew, er;
        @(negedge clk);
        full  = rand_flags ? 1'($urandom) : (occ() == DEPTH);
        empty = rand_flags ? 1'($urandom) : (occ() == 0);
        rst = rs; i_valid_s = v; i_ready_m = r; i_flush = fl;
        i_full = full; i_empty = empty;
        ew = !rs && v && !full && !fl;
        er = !rs && r && !empty && !fl;
        #1;
        check("wr_en", o_wr_en, ew);
        check("rd_en", o_rd_en, er);
        @(posedge clk);
        if (rs || fl) begin
            m_wr = 0; m_rd = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (ew) m_wr = (m_wr + 1) % PMOD;
            if (er) m_rd = (m_rd + 1) % PMOD;
            m_rv = er;
            if (v && full)  m_ovf = 1;
            if (r && empty) m_unf = 1;
        end
        #1;
        check("wr_addr", wr_addr, m_wr);
        check("rd_addr", rd_addr, m_rd);
        check("rd_valid", o_rd_valid, m_rv);
        check("overflow", o_overflow, m_ovf);
        check("underflow", o_underflow, m_unf);
    endtask

    initial begin
        rst = 1; i_valid_s = 0; i_ready_m = 0; i_flush = 0; i_full = 0; i_empty = 1;
        cycle(0, 0, 0, 1);
        cycle(1, 1, 1, 1);
        check("reset_wr", wr_addr, 0);
        // fill to full, then one blocked write
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0);
        check("fill_wr", wr_addr, 5'h10);
        check("fill_rd", rd_addr, 0);
        cycle(1, 0, 0, 0);
        check("full_flag", i_full, 1);
        check("full_wr_en_blocked", wr_addr, 5'h10);
        check("ovf_set", o_overflow, 1);
        // drain, then one blocked read
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 0);
            check("drain_rv", o_rd_valid, 1);
        end
        check("drain_rd", rd_addr, 5'h10);
        cycle(0, 1, 0, 0);
        check("drain_rv_off", o_rd_valid, 0);
        check("unf_set", o_underflow, 1);
        check("ovf_sticky", o_overflow, 1);
        // occupancy 1, then steady stream through the wrap point
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0, 0);
            check("stream_occ", 32'((wr_addr - rd_addr) & 5'h1F), 1);
        end
        check("stream_wr", wr_addr, 5'h19);
        check("stream_rd", rd_addr, 5'h18);
        // occupancy 5 flushed with both requests active
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        check("occ5", 32'((wr_addr - rd_addr) & 5'h1F), 5);
        cycle(1, 1, 1, 0);
        check("flush_wr", wr_addr, 0);
        check("flush_rd", rd_addr, 0);
        check("flush_rv", o_rd_valid, 0);
        check("flush_unf", o_underflow, 0);
        // reset mid-stream with overflow pending
        for (int i = 0; i <= DEPTH; i++) cycle(1, 0, 0, 0);
        check("pre_rst_ovf", o_overflow, 1);
        cycle(1, 1, 0, 1);
        check("rst_ovf", o_overflow, 0);
        check("rst_wr", wr_addr, 0);
        cycle(1, 0, 0, 0);
        check("post_rst_wr", wr_addr, 1);
        // randomized traffic, occasionally with arbitrary comparator flags
        for (int i = 0; i < 3000; i++) begin
            rand_flags = ($urandom_range(0, 3) == 0);
            cycle(1'($urandom), 1'($urandom), $urandom_range(0, 40) == 0,
                  $urandom_range(0, 80) == 0);
            if (rand_flags) begin
                rand_flags = 0;
                cycle(0, 0, 1, 0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
